// File: rtl/cmp_lgez_pkg.sv
// Shared types and the LGEZ combining cell for the serial magnitude comparator.
// Codes: 10 X>Y, 01 X<Y, 11 equal and nonzero, 00 equal and zero (fold identity).
package cmp_lgez_pkg;

    localparam logic [1:0] LGEZ_GT   = 2'b10;
    localparam logic [1:0] LGEZ_LT   = 2'b01;
    localparam logic [1:0] LGEZ_EQ   = 2'b11;
    localparam logic [1:0] LGEZ_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // l is the code of the lower bits, m = {mx, my} is the next higher bit pair.
    function automatic logic [1:0] lgez_cell(input logic [1:0] l, input logic [1:0] m);
        logic lx, ly, mx, my, rx, ry;
        lx = l[1];
        ly = l[0];
        mx = m[1];
        my = m[0];
        rx = (mx & ~my) | (mx & ~ly) | (~my & lx) | (mx & lx);
        ry = (~mx & ly) | (my & ly) | (my & ~lx) | (~mx & my);
        return {rx, ry};
    endfunction

endpackage

// File: rtl/cmp_lgez_fold_stage.sv
// Combinational chain of LGEZ cells folding a bit slice, LSB first, into a running code.
// i_msb_swap exchanges X/Y on the top cell so two's-complement sign bits rank correctly.
module cmp_lgez_fold_stage
    import cmp_lgez_pkg::*;
#(
    parameter int P_BITS_PER_CYCLE = 2
) (
    input  logic [1:0]                  code_in,
    input  logic [P_BITS_PER_CYCLE-1:0] x_slice,
    input  logic [P_BITS_PER_CYCLE-1:0] y_slice,
    input  logic                        i_msb_swap,
    output logic [1:0]                  code_out
);

    logic [1:0] chain [P_BITS_PER_CYCLE+1];

    assign chain[0] = code_in;

    genvar gi;
    generate
        for (gi = 0; gi < P_BITS_PER_CYCLE; gi++) begin : g_cell
            logic [1:0] m_pair;
            if (gi == P_BITS_PER_CYCLE - 1) begin : g_top
                assign m_pair = i_msb_swap ? {y_slice[gi], x_slice[gi]}
                                           : {x_slice[gi], y_slice[gi]};
            end else begin : g_low
                assign m_pair = {x_slice[gi], y_slice[gi]};
            end
            assign chain[gi+1] = lgez_cell(chain[gi], m_pair);
        end
    endgenerate

    assign code_out = chain[P_BITS_PER_CYCLE];

endmodule

// File: rtl/cmp_lgez_serial.sv
// Multi-cycle LGEZ magnitude comparator, P_BITS_PER_CYCLE bits per clock, LSB first.
// Define CMP_LGEZ_SIGNED_EN for a two's-complement compare; otherwise unsigned.
module cmp_lgez_serial
    import cmp_lgez_pkg::*;
#(
    parameter int P_WIDTH          = 8,
    parameter int P_BITS_PER_CYCLE = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [P_WIDTH-1:0] iv_x,
    input  logic [P_WIDTH-1:0] iv_y,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_Rx,
    output logic               o_Ry,
    output logic               o_busy
);

    localparam int N     = P_WIDTH / P_BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (P_WIDTH < 2 || P_BITS_PER_CYCLE < 1 || P_BITS_PER_CYCLE > P_WIDTH ||
            (P_WIDTH % P_BITS_PER_CYCLE) != 0) begin : g_param_err
            $error("cmp_lgez_serial: P_WIDTH must be >= 2 and a multiple of P_BITS_PER_CYCLE");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [P_WIDTH-1:0] x_sh_reg, x_sh_next, y_sh_reg, y_sh_next;
    logic [P_WIDTH-1:0] x_shifted, y_shifted;
    logic [1:0]         code_reg, code_next, fold_code;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               last_fold, msb_swap;

    assign last_fold = (cnt_reg == CNT_LAST);

`ifdef CMP_LGEZ_SIGNED_EN
    // Only the slice holding the sign bit gets its top cell swapped.
    assign msb_swap = last_fold;
`else
    assign msb_swap = 1'b0;
`endif

    generate
        if (P_BITS_PER_CYCLE == P_WIDTH) begin : g_shift_all
            assign x_shifted = '0;
            assign y_shifted = '0;
        end else begin : g_shift
            assign x_shifted = {{P_BITS_PER_CYCLE{1'b0}}, x_sh_reg[P_WIDTH-1:P_BITS_PER_CYCLE]};
            assign y_shifted = {{P_BITS_PER_CYCLE{1'b0}}, y_sh_reg[P_WIDTH-1:P_BITS_PER_CYCLE]};
        end
    endgenerate

    cmp_lgez_fold_stage #(
        .P_BITS_PER_CYCLE(P_BITS_PER_CYCLE)
    ) u_fold (
        .code_in   (code_reg),
        .x_slice   (x_sh_reg[P_BITS_PER_CYCLE-1:0]),
        .y_slice   (y_sh_reg[P_BITS_PER_CYCLE-1:0]),
        .i_msb_swap(msb_swap),
        .code_out  (fold_code)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            x_sh_reg  <= '0;
            y_sh_reg  <= '0;
            code_reg  <= LGEZ_ZERO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            x_sh_reg  <= x_sh_next;
            y_sh_reg  <= y_sh_next;
            code_reg  <= code_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_sh_next  = x_sh_reg;
        y_sh_next  = y_sh_reg;
        code_next  = code_reg;
        cnt_next   = cnt_reg;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        o_Rx       = 1'b0;
        o_Ry       = 1'b0;

        case (state_reg)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    x_sh_next  = iv_x;
                    y_sh_next  = iv_y;
                    code_next  = LGEZ_ZERO;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                o_busy    = 1'b1;
                x_sh_next = x_shifted;
                y_sh_next = y_shifted;
                code_next = fold_code;
                if (last_fold) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
                o_Rx    = code_reg[1];
                o_Ry    = code_reg[0];
                // Result and new operands can both handshake on the same edge.
                if (i_ready) begin
                    if (i_valid) begin
                        x_sh_next  = iv_x;
                        y_sh_next  = iv_y;
                        code_next  = LGEZ_ZERO;
                        cnt_next   = '0;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmp_lgez_serial.sv
// Scoreboard bench for cmp_lgez_serial (8-bit, 2 bits/cycle) plus 1- and 8-bit/cycle variants.
// Expected codes follow CMP_LGEZ_SIGNED_EN when it is defined for the build.
module tb_cmp_lgez_serial;

    localparam int W   = 8;
    localparam int BPC = 2;
    localparam int N   = W / BPC;

`ifdef CMP_LGEZ_SIGNED_EN
    localparam logic [1:0] EXP_80_7F = 2'b01;
`else
    localparam logic [1:0] EXP_80_7F = 2'b10;
`endif

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         i_valid  = 1'b0;
    logic         rdy_ctl  = 1'b1;
    logic         rand_rdy = 1'b0;
    logic         rnd_bit  = 1'b1;
    logic         b2b_mode = 1'b0;
    logic [W-1:0] iv_x     = '0;
    logic [W-1:0] iv_y     = '0;
    logic         i_ready;
    logic         o_ready, o_valid, o_Rx, o_Ry, o_busy;

    logic         alt_valid = 1'b0;
    logic [W-1:0] ax = '0;
    logic [W-1:0] ay = '0;
    logic         b1_ready, b1_valid, b1_rx, b1_ry, b1_busy;
    logic         b8_ready, b8_valid, b8_rx, b8_ry, b8_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [1:0] exp_q [$];
    int         acc_q [$];

    assign i_ready = rand_rdy ? rnd_bit : rdy_ctl;

    cmp_lgez_serial #(.P_WIDTH(W), .P_BITS_PER_CYCLE(BPC)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .iv_x(iv_x), .iv_y(iv_y), .o_valid(o_valid), .i_ready(i_ready),
        .o_Rx(o_Rx), .o_Ry(o_Ry), .o_busy(o_busy)
    );

    cmp_lgez_serial #(.P_WIDTH(W), .P_BITS_PER_CYCLE(1)) u_bpc1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(alt_valid), .o_ready(b1_ready),
        .iv_x(ax), .iv_y(ay), .o_valid(b1_valid), .i_ready(1'b1),
        .o_Rx(b1_rx), .o_Ry(b1_ry), .o_busy(b1_busy)
    );

    cmp_lgez_serial #(.P_WIDTH(W), .P_BITS_PER_CYCLE(W)) u_bpc8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(alt_valid), .o_ready(b8_ready),
        .iv_x(ax), .iv_y(ay), .o_valid(b8_valid), .i_ready(1'b1),
        .o_Rx(b8_rx), .o_Ry(b8_ry), .o_busy(b8_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [1:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef CMP_LGEZ_SIGNED_EN
        if ($signed(x) > $signed(y)) return 2'b10;
        if ($signed(x) < $signed(y)) return 2'b01;
`else
        if (x > y) return 2'b10;
        if (x < y) return 2'b01;
`endif
        return (x == '0) ? 2'b00 : 2'b11;
    endfunction

    // Called at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] exp);
        int t;
        t = 0;
        iv_x    = x;
        iv_y    = y;
        i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!o_ready) begin
            fail("send_timeout");
            i_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        acc_q.push_back(cyc + 1);
        $display("send x=%02h y=%02h expect %02b", x, y, exp);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every result handshake and checks hold/latency rules.
    logic       prev_stall = 1'b0;
    logic [1:0] held       = 2'b00;
    int         last_res   = -1;

    always @(negedge clk) begin
        if (!b2b_mode) last_res = -1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else if (o_valid) begin
            chk("ready_follows_consumer", o_ready, i_ready);
            if (prev_stall) begin
                chk("hold_code", {o_Rx, o_Ry}, held);
            end else begin
                if (acc_q.size() == 0) fail("result_without_accept");
                else chk("latency", cyc - acc_q.pop_front(), N);
                if (b2b_mode && last_res >= 0) chk("b2b_gap", cyc - last_res, N + 1);
                last_res = cyc;
            end
            if (i_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    $display("result code=%b%b expect %02b", o_Rx, o_Ry, e);
                    chk("result_code", {o_Rx, o_Ry}, e);
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                held       = {o_Rx, o_Ry};
            end
        end else begin
            prev_stall = 1'b0;
            chk("code_zero_when_invalid", {o_Rx, o_Ry}, 2'b00);
        end
    end

    logic [W-1:0] dir_x   [5] = '{8'h5A, 8'h00, 8'h01, 8'h3F, 8'h80};
    logic [W-1:0] dir_y   [5] = '{8'h5A, 8'h00, 8'h00, 8'h40, 8'h7F};
    logic [1:0]   dir_e   [5] = '{2'b11, 2'b00, 2'b10, 2'b01, EXP_80_7F};
    logic [W-1:0] alt_x   [3] = '{8'h80, 8'h5A, 8'h3F};
    logic [W-1:0] alt_y   [3] = '{8'h7F, 8'h5A, 8'h40};
    logic [1:0]   alt_e   [3] = '{EXP_80_7F, 2'b11, 2'b01};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", o_valid, 1'b0);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_code", {o_Rx, o_Ry}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", o_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed vectors with the consumer always ready.
        for (int i = 0; i < 5; i++) send(dir_x[i], dir_y[i], dir_e[i]);
        drain();

        // Backpressure: consumer stalls 5 cycles while a new pair waits upstream.
        rdy_ctl = 1'b0;
        send(8'h3F, 8'h40, 2'b01);
        begin
            int t;
            t = 0;
            while (!o_valid && t < 20) begin
                t++;
                @(negedge clk);
            end
            if (!o_valid) fail("backpressure_no_valid");
        end
        iv_x    = 8'h01;
        iv_y    = 8'h00;
        i_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rdy_ctl = 1'b1;
        send(8'h01, 8'h00, 2'b10);
        drain();

        // Back-to-back: valid and ready held high, one result per N+1 cycles.
        b2b_mode = 1'b1;
        send(8'h5A, 8'h5A, 2'b11);
        send(8'h01, 8'h00, 2'b10);
        send(8'h3F, 8'h40, 2'b01);
        send(8'h00, 8'h00, 2'b00);
        send(8'hC3, 8'hC2, 2'b10);
        drain();
        b2b_mode = 1'b0;

        // Reset in the middle of a fold discards the pair.
        send(8'hAA, 8'h55, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", o_valid, 1'b0);
        chk("midreset_busy", o_busy, 1'b0);
        chk("midreset_code", {o_Rx, o_Ry}, 2'b00);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("postreset_ready", o_ready, 1'b1);
        chk("postreset_valid", o_valid, 1'b0);
        @(posedge clk);
        #1;
        send(8'hFF, 8'hFE, 2'b10);
        drain();

        // Random pairs with random consumer stalls and idle gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] rx, ry;
            rx = 8'($urandom_range(0, 255));
            ry = (i % 4 == 0) ? rx : 8'($urandom_range(0, 255));
            send(rx, ry, ref_cmp(rx, ry));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;

        // Same pairs through the 1-bit and 8-bit-per-cycle variants.
        for (int p = 0; p < 3; p++) begin
            int         k1, k8;
            logic [1:0] c1, c8;
            k1 = -1;
            k8 = -1;
            c1 = 2'b00;
            c8 = 2'b00;
            ax = alt_x[p];
            ay = alt_y[p];
            alt_valid = 1'b1;
            @(negedge clk);
            chk("bpc1_ready", b1_ready, 1'b1);
            chk("bpc8_ready", b8_ready, 1'b1);
            @(posedge clk);
            #1;
            alt_valid = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (k == 1) begin
                    chk("bpc1_busy", b1_busy, 1'b1);
                    chk("bpc8_busy", b8_busy, 1'b0);
                end
                if (b1_valid && k1 < 0) begin
                    k1 = k;
                    c1 = {b1_rx, b1_ry};
                end
                if (b8_valid && k8 < 0) begin
                    k8 = k;
                    c8 = {b8_rx, b8_ry};
                end
            end
            $display("alt x=%02h y=%02h bpc1 code=%02b edges=%0d bpc8 code=%02b edges=%0d",
                     alt_x[p], alt_y[p], c1, k1, c8, k8);
            chk("bpc1_latency", k1, 8);
            chk("bpc8_latency", k8, 1);
            chk("bpc1_code", c1, alt_e[p]);
            chk("bpc8_code", c8, alt_e[p]);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
